// File: rtl/systolic_pkg.sv
// Shared types and constants for the 2x2 systolic array sequencer.
package systolic_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 16;

  // Element positions inside a packed {X11,X10,X01,X00} matrix word.
  localparam int IDX00 = 0;
  localparam int IDX01 = 1;
  localparam int IDX10 = 2;
  localparam int IDX11 = 3;

  // Operand wavefront length for a 2x2 product (2 + 2 - 1 diagonals).
  localparam int FEED_STEPS = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_CAPTURE,
    S_DONE
  } state_t;

  // Pull one element out of a packed default-width matrix word.
  function automatic logic [DEF_DATA_W-1:0] mat_elem(
    input logic [4*DEF_DATA_W-1:0] m,
    input int                      idx
  );
    return m[idx*DEF_DATA_W +: DEF_DATA_W];
  endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Maps a feed step onto the skewed row/column operands for the 2x2 array.
// Purely combinational; the parent registers the result.
module systolic_skew_gen
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]          step,
  input  logic [4*DATA_W-1:0] mat_a,
  input  logic [4*DATA_W-1:0] mat_b,
  output logic [DATA_W-1:0]   a0,
  output logic [DATA_W-1:0]   a1,
  output logic [DATA_W-1:0]   b0,
  output logic [DATA_W-1:0]   b1
);

  logic [DATA_W-1:0] a00, a01, a10, a11;
  logic [DATA_W-1:0] b00, b01, b10, b11;

  assign a00 = mat_a[IDX00*DATA_W +: DATA_W];
  assign a01 = mat_a[IDX01*DATA_W +: DATA_W];
  assign a10 = mat_a[IDX10*DATA_W +: DATA_W];
  assign a11 = mat_a[IDX11*DATA_W +: DATA_W];
  assign b00 = mat_b[IDX00*DATA_W +: DATA_W];
  assign b01 = mat_b[IDX01*DATA_W +: DATA_W];
  assign b10 = mat_b[IDX10*DATA_W +: DATA_W];
  assign b11 = mat_b[IDX11*DATA_W +: DATA_W];

  // Row 1 / column 1 lag row 0 / column 0 by one step so that matching
  // k-terms meet in each PE on the same cycle.
  always_comb begin
    a0 = '0;
    a1 = '0;
    b0 = '0;
    b1 = '0;
    case (step)
      2'd0: begin
        a0 = a00;
        b0 = b00;
      end
      2'd1: begin
        a0 = a01;
        a1 = a10;
        b0 = b10;
        b1 = b01;
      end
      2'd2: begin
        a1 = a11;
        b1 = b11;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/systolic_2x2_ctrl.sv
// Job sequencer for the 2x2 output-stationary systolic MAC array: accepts a
// pair of matrices, clears and feeds the array, then returns its results.
module systolic_2x2_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ACC_W        = DEF_ACC_W,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [4*DATA_W-1:0] cmd_a,
  input  logic [4*DATA_W-1:0] cmd_b,
  output logic                arr_rst,
  output logic                arr_en,
  output logic [DATA_W-1:0]   arr_a0,
  output logic [DATA_W-1:0]   arr_a1,
  output logic [DATA_W-1:0]   arr_b0,
  output logic [DATA_W-1:0]   arr_b1,
  input  logic [ACC_W-1:0]    arr_c00,
  input  logic [ACC_W-1:0]    arr_c01,
  input  logic [ACC_W-1:0]    arr_c10,
  input  logic [ACC_W-1:0]    arr_c11,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [4*ACC_W-1:0]  res_c,
  output logic                busy,
  output logic [15:0]         job_count
);

  // One counter serves both FEED steps and DRAIN cycles.
  localparam int CNT_MAX = (DRAIN_CYCLES > FEED_STEPS) ? DRAIN_CYCLES : FEED_STEPS;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_STEPS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t             state, nxt_state;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic [4*DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0]  sk_a0, sk_a1, sk_b0, sk_b1;
  logic               accept, res_hs, feed_nxt;

  assign accept   = (state == S_IDLE) && cmd_valid && cmd_ready;
  assign res_hs   = (state == S_DONE) && res_valid && res_ready;
  assign feed_nxt = (nxt_state == S_FEED);

  // Operands are looked up for the step about to be entered so that the
  // registered outputs line up with the registered state.
  systolic_skew_gen #(.DATA_W(DATA_W)) u_skew (
    .step  (nxt_cnt[1:0]),
    .mat_a (a_q),
    .mat_b (b_q),
    .a0    (sk_a0),
    .a1    (sk_a1),
    .b0    (sk_b0),
    .b1    (sk_b1)
  );

  // Next-state and step counter.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) nxt_state = S_CLEAR;
      end
      S_CLEAR: begin
        nxt_state = S_FEED;
        nxt_cnt   = '0;
      end
      S_FEED: begin
        if (cnt == FEED_LAST) begin
          nxt_state = S_DRAIN;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) nxt_state = S_CAPTURE;
        else                   nxt_cnt   = cnt + 1'b1;
      end
      S_CAPTURE: nxt_state = S_DONE;
      S_DONE: begin
        if (res_hs) nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // State register plus every output, each decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      arr_rst   <= 1'b1;
      arr_en    <= 1'b0;
      arr_a0    <= '0;
      arr_a1    <= '0;
      arr_b0    <= '0;
      arr_b1    <= '0;
      res_valid <= 1'b0;
      res_c     <= '0;
      job_count <= '0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      cmd_ready <= (nxt_state == S_IDLE);
      busy      <= (nxt_state != S_IDLE);
      arr_rst   <= (nxt_state == S_CLEAR);
      arr_en    <= feed_nxt || (nxt_state == S_DRAIN);
      arr_a0    <= feed_nxt ? sk_a0 : '0;
      arr_a1    <= feed_nxt ? sk_a1 : '0;
      arr_b0    <= feed_nxt ? sk_b0 : '0;
      arr_b1    <= feed_nxt ? sk_b1 : '0;
      res_valid <= (nxt_state == S_DONE);
      if (accept) begin
        a_q <= cmd_a;
        b_q <= cmd_b;
      end
      if (state == S_CAPTURE) res_c <= {arr_c11, arr_c10, arr_c01, arr_c00};
      if (res_hs) job_count <= job_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_systolic_2x2_ctrl.sv
// Bench for systolic_2x2_ctrl: behavioural 2x2 array in the loop, results
// checked against a plain matrix product mod 2^16.
module tb_systolic_2x2_ctrl;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [4*DW-1:0] cmd_a, cmd_b;
  logic          arr_rst, arr_en;
  logic [DW-1:0] arr_a0, arr_a1, arr_b0, arr_b1;
  logic [AW-1:0] arr_c00, arr_c01, arr_c10, arr_c11;
  logic          res_valid, res_ready;
  logic [4*AW-1:0] res_c;
  logic          busy;
  logic [15:0]   job_count;

  int npass = 0;
  int ntotal = 0;
  int exp_jobs = 0;

  logic [7:0]    rec_rst, rec_en;
  logic [DW-1:0] ra0[8], ra1[8], rb0[8], rb1[8];

  always #5 clk = ~clk;

  systolic_2x2_ctrl #(.DATA_W(DW), .ACC_W(AW), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .arr_rst(arr_rst), .arr_en(arr_en),
    .arr_a0(arr_a0), .arr_a1(arr_a1), .arr_b0(arr_b0), .arr_b1(arr_b1),
    .arr_c00(arr_c00), .arr_c01(arr_c01), .arr_c10(arr_c10), .arr_c11(arr_c11),
    .res_valid(res_valid), .res_ready(res_ready), .res_c(res_c),
    .busy(busy), .job_count(job_count)
  );

  // Output-stationary 2x2 array: a flows right, b flows down, each PE
  // accumulates its local product while enabled.
  logic [DW-1:0] pa00, pb00, pa10, pb01;
  always @(posedge clk) begin
    if (arr_rst) begin
      pa00 <= '0; pb00 <= '0; pa10 <= '0; pb01 <= '0;
      arr_c00 <= '0; arr_c01 <= '0; arr_c10 <= '0; arr_c11 <= '0;
    end else if (arr_en) begin
      arr_c00 <= arr_c00 + arr_a0 * arr_b0;
      arr_c01 <= arr_c01 + pa00 * arr_b1;
      arr_c10 <= arr_c10 + arr_a1 * pb00;
      arr_c11 <= arr_c11 + pa10 * pb01;
      pa00 <= arr_a0;
      pb00 <= arr_b0;
      pa10 <= arr_a1;
      pb01 <= arr_b1;
    end
  end

  // Reference: C = A x B with 16-bit wrap, packed {C11,C10,C01,C00}.
  function automatic logic [63:0] matmul(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] c;
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        c = '0;
        for (int k = 0; k < 2; k++)
          c = c + 16'(a[(i*2+k)*8 +: 8]) * 16'(b[(k*2+j)*8 +: 8]);
        r[(i*2+j)*16 +: 16] = c;
      end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic record(input int n);
    rec_rst[n] = arr_rst;
    rec_en[n]  = arr_en;
    ra0[n] = arr_a0; ra1[n] = arr_a1; rb0[n] = arr_b0; rb1[n] = arr_b1;
  endtask

  // Offer one job from IDLE and wait (bounded) for res_valid.
  // lat counts clock edges from the accept edge.
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, output int lat);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom;
    lat = 0;
    while (!res_valid && lat < 30) begin
      if (lat < 8) record(lat);
      @(negedge clk);
      lat++;
    end
    if (lat < 8) record(lat);
  endtask

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int stall);
    int lat;
    logic [63:0] exp;
    start_and_wait(a, b, lat);
    exp = matmul(a, b);
    check("latency", 64'(lat), 64'd7);
    check("res_c", res_c, exp);
    // CLEAR at edge 0, FEED 1..3, DRAIN 4..5, CAPTURE 6, DONE 7
    check("arr_rst_seq", 64'(rec_rst), 64'h01);
    check("arr_en_seq", 64'(rec_en), 64'h3E);
    check("a0_seq", 64'({ra0[1], ra0[2], ra0[3]}), 64'({a[7:0], a[15:8], 8'h00}));
    check("a1_seq", 64'({ra1[1], ra1[2], ra1[3]}), 64'({8'h00, a[23:16], a[31:24]}));
    check("b0_seq", 64'({rb0[1], rb0[2], rb0[3]}), 64'({b[7:0], b[23:16], 8'h00}));
    check("b1_seq", 64'({rb1[1], rb1[2], rb1[3]}), 64'({8'h00, b[15:8], b[31:24]}));
    check("ops_quiet", 64'({ra0[0], ra1[0], rb0[0], rb1[0], ra0[4], ra1[4], rb0[4], rb1[4]}), 64'd0);
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1; cmd_a = $urandom; cmd_b = $urandom;
      @(negedge clk);
      check("bp_res_c", res_c, exp);
      check("bp_valid", 64'(res_valid), 64'd1);
      check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_jobs = (exp_jobs + 1) & 16'hFFFF;
    check("hs_valid_low", 64'(res_valid), 64'd0);
    check("job_count", 64'(job_count), 64'(exp_jobs));
    check("hs_idle", 64'({cmd_ready, busy}), 64'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, k, r, cyc;
    int acc[3];
    logic [31:0] ja[3], jb[3];

    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0; cmd_a = '0; cmd_b = '0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_arr_ctl", 64'({arr_rst, arr_en}), 64'b10);
    check("rst_ops", 64'({arr_a0, arr_a1, arr_b0, arr_b1}), 64'd0);
    check("rst_res", 64'({res_valid, busy}), 64'd0);
    check("rst_res_c", res_c, 64'd0);
    check("rst_job_count", 64'(job_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'({cmd_ready, arr_rst, busy}), 64'b100);

    // Basic job
    run_job(32'h04030201, 32'h08070605, 0);
    check("basic_c", res_c, {16'd50, 16'd43, 16'd22, 16'd19});

    // All-255 operands wrap the accumulators
    run_job(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("overflow_c", res_c, {4{16'hFC02}});

    // Back-pressure with a competing command offered while held
    run_job($urandom, $urandom, 5);

    // Random jobs with random stalls
    for (int i = 0; i < 4; i++) run_job($urandom, $urandom, $urandom_range(0, 3));

    // Reset in the middle of FEED (step 1)
    check("mf_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_a = $urandom; cmd_b = $urandom;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mf_in_feed", 64'(arr_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_jobs = 0;
    check("mf_arr_ctl", 64'({arr_rst, arr_en, res_valid, busy}), 64'b1000);
    check("mf_job_count", 64'(job_count), 64'd0);
    @(negedge clk);
    check("mf_ready_again", 64'(cmd_ready), 64'd1);

    // Identity A after the aborted job
    run_job(32'h01000001, 32'h08070605, 0);
    check("identity_c", res_c, {16'd8, 16'd7, 16'd6, 16'd5});

    // Reset and res_ready together in DONE: reset wins
    start_and_wait($urandom, $urandom, lat);
    check("rd_latency", 64'(lat), 64'd7);
    rst = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; res_ready = 1'b0;
    exp_jobs = 0;
    check("rd_job_count", 64'(job_count), 64'd0);
    check("rd_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    check("rd_ready", 64'(cmd_ready), 64'd1);

    // Back-to-back jobs with cmd_valid and res_ready held high. Accept edges
    // land nine clocks apart: CLEAR, 3xFEED, 2xDRAIN, CAPTURE, DONE, IDLE.
    for (int i = 0; i < 3; i++) begin ja[i] = $urandom; jb[i] = $urandom; end
    res_ready = 1'b1; k = 0; r = 0; cyc = 0;
    while (r < 3 && cyc < 200) begin
      cmd_valid = (k < 3);
      if (cmd_ready && k < 3) begin
        acc[k] = cyc; cmd_a = ja[k]; cmd_b = jb[k]; k++;
      end
      if (res_valid) begin
        check("b2b_res_c", res_c, matmul(ja[r], jb[r]));
        r++;
      end
      @(negedge clk);
      cyc++;
    end
    res_ready = 1'b0; cmd_valid = 1'b0;
    check("b2b_results", 64'(r), 64'd3);
    check("b2b_gap01", 64'(acc[1] - acc[0]), 64'd9);
    check("b2b_gap12", 64'(acc[2] - acc[1]), 64'd9);
    check("b2b_job_count", 64'(job_count), 64'd3);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
